fft_iter_addr_gen: RTL

Address generator for the iterative radix-2 FFT core. It sits directly downstream of the 4-cycle-per-butterfly control unit and consumes its `ADDR_EN`, `ADDR_RST`, `LAY_EN` and `RAM_EN_R` strobes. It produces the in-place dual-port RAM read and write addresses for butterfly operands A/B and the twiddle ROM address. For each layer it tracks butterfly and layer indices, and it latches the read pair so that the writeback of the same butterfly returns to the same locations.

---
 rtl/fft_iter_addr_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 DIT FFT: RAM read/write pairs and twiddle index.
// Optional FFT_AGEN_TWREG_EN adds one register stage on TW_ADDR for a registered twiddle ROM.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ADDR_RST,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    input  logic              RD_LATCH,
    output logic [LAYERS-1:0] RD_ADDR_A,
    output logic [LAYERS-1:0] RD_ADDR_B,
    output logic [LAYERS-1:0] WR_ADDR_A,
    output logic [LAYERS-1:0] WR_ADDR_B,
    output logic [LAYERS-2:0] TW_ADDR,
    output logic [LayWL-1:0]  LAYER_IDX,
    output logic              LAST_BUT,
    output logic              DONE
);

    logic [ButtWL-1:0] r_b;
    logic [LayWL-1:0]  r_l;
    logic [LAYERS-1:0] r_rd_a;
    logic [LAYERS-1:0] r_rd_b;
    logic [LAYERS-1:0] r_wr_a;
    logic [LAYERS-1:0] r_wr_b;
    logic [LAYERS-2:0] r_tw;
    logic              r_last;
    logic              r_done;

    logic [ButtWL-1:0] w_b_nxt;
    logic [LayWL-1:0]  w_l_nxt;
    logic              w_done_nxt;
    logic [LAYERS-1:0] w_mask;
    logic [LAYERS-1:0] w_bx;
    logic [LAYERS-1:0] w_a;
    logic [LAYERS-1:0] w_bb;
    logic [ButtWL-1:0] w_pos;
    logic [LayWL-1:0]  w_tsh;
    logic [LAYERS-2:0] w_tw;
    logic              w_last;

    always_comb begin
        w_b_nxt    = r_b;
        w_l_nxt    = r_l;
        w_done_nxt = 1'b0;
        if (ADDR_RST) begin
            w_b_nxt = '0;
            w_l_nxt = '0;
        end else if (ADDR_EN) begin
            if (LAY_EN) begin
                w_b_nxt = '0;
                if (r_l == LayWL'(LAYERS-1)) begin
                    w_l_nxt    = '0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_l_nxt = r_l + LayWL'(1);
                end
            end else if (r_b == ButtWL'(BUTTERFLYES-1)) begin
                w_b_nxt = '0;
            end else begin
                w_b_nxt = r_b + ButtWL'(1);
            end
        end
    end

    // Addresses come from the next-state counters so they move on the same edge as b/l
    always_comb begin
        w_mask = (LAYERS'(1) << w_l_nxt) - LAYERS'(1);
        w_bx   = {1'b0, w_b_nxt};
        w_a    = ((w_bx & ~w_mask) << 1) | (w_bx & w_mask);
        w_bb   = w_a | (LAYERS'(1) << w_l_nxt);
        w_pos  = w_b_nxt & w_mask[ButtWL-1:0];
        w_tsh  = LayWL'(LAYERS-1) - w_l_nxt;
        w_tw   = w_pos << w_tsh;
        w_last = (w_b_nxt == ButtWL'(BUTTERFLYES-1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_b    <= '0;
            r_l    <= '0;
            r_rd_a <= '0;
            r_rd_b <= LAYERS'(1);
            r_wr_a <= '0;
            r_wr_b <= LAYERS'(1);
            r_tw   <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_b    <= w_b_nxt;
            r_l    <= w_l_nxt;
            r_rd_a <= w_a;
            r_rd_b <= w_bb;
            r_tw   <= w_tw;
            r_last <= w_last;
            r_done <= w_done_nxt;
            if (ADDR_RST) begin
                r_wr_a <= '0;
                r_wr_b <= LAYERS'(1);
            end else if (RD_LATCH) begin
                r_wr_a <= r_rd_a;
                r_wr_b <= r_rd_b;
            end
        end
    end

`ifdef FFT_AGEN_TWREG_EN
    logic [LAYERS-2:0] r_tw_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tw_d <= '0;
        end else begin
            r_tw_d <= r_tw;
        end
    end

    assign TW_ADDR = r_tw_d;
`else
    assign TW_ADDR = r_tw;
`endif

    assign RD_ADDR_A = r_rd_a;
    assign RD_ADDR_B = r_rd_b;
    assign WR_ADDR_A = r_wr_a;
    assign WR_ADDR_B = r_wr_b;
    assign LAYER_IDX = r_l;
    assign LAST_BUT  = r_last;
    assign DONE      = r_done;

endmodule
